// File: rtl/approx_mac_pkg.sv
// Shared constants, output-state encoding and the saturating adder used by the
// approximate Wallace-tree multiply-accumulate reader.
package approx_mac_pkg;

  localparam int PROD_W        = 16;
  localparam int ACC_W_DEFAULT = 24;
  localparam int CNT_W_DEFAULT = 8;
  localparam int SAT_W         = 64;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  // Returns {clamped, sum}; sum is limited to 2^w - 1 (w <= SAT_W).
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int unsigned      w);
    logic [SAT_W:0] full_sum;
    logic [SAT_W:0] max_val;
    full_sum = {1'b0, a} + {1'b0, b};
    max_val  = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
    if (full_sum > max_val) return {1'b1, max_val[SAT_W-1:0]};
    else                    return {1'b0, full_sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/approx_mac_resolve_stage.sv
// Stage 1: accepts a redundant (sum, carry) product and registers its exact
// carry-propagate resolution, holding while the accumulate stage is stalled.
module approx_mac_resolve_stage
  import approx_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  input  logic              in_last,
  input  logic              consume,
  output logic              p1_valid,
  output logic [PROD_W-1:0] p1_prod,
  output logic              p1_last
);

  logic load;
  assign load = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_prod  <= '0;
      p1_last  <= 1'b0;
    end else if (load) begin
      p1_valid <= 1'b1;
      p1_prod  <= in_sum + in_carry;
      p1_last  <= in_last;
    end else if (consume) begin
      p1_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/approx_wallace_mac_accumulator.sv
// Resolves redundant multiplier products and accumulates them per group into a
// saturating accumulator, presenting each group result on a valid/ready port.
module approx_wallace_mac_accumulator
  import approx_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  logic              p1_valid;
  logic [PROD_W-1:0] p1_prod;
  logic              p1_last;

  logic [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              sat, acc_clamp;
  logic [SAT_W-1-ACC_W:0] acc_unused;
  logic [SAT_W-CNT_W:0]   cnt_unused;

  logic       stall, advance, close;
  out_state_e out_state;

  // A closing beat may only retire once the held result can be replaced.
  assign stall    = p1_valid && p1_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign advance  = p1_valid && !stall;
  assign close    = advance && p1_last;
  assign out_valid = (out_state == OUT_FULL);

  assign {acc_clamp, acc_unused, acc_next} =
    sat_add(SAT_W'(acc), SAT_W'(p1_prod), ACC_W);
  assign {cnt_unused, cnt_next} =
    sat_add(SAT_W'(cnt), SAT_W'(1), CNT_W);

  approx_mac_resolve_stage u_resolve (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .in_last  (in_last),
    .consume  (advance),
    .p1_valid (p1_valid),
    .p1_prod  (p1_prod),
    .p1_last  (p1_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= OUT_EMPTY;
      out_acc   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
    end else begin
      if (close) begin
        out_acc   <= acc_next;
        out_count <= cnt_next;
        out_sat   <= sat | acc_clamp;
        acc       <= '0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else if (advance) begin
        acc <= acc_next;
        cnt <= cnt_next;
        sat <= sat | acc_clamp;
      end

      // Coincident drain and close keeps FULL so the new result has no bubble.
      case (out_state)
        OUT_EMPTY: if (close)               out_state <= OUT_FULL;
        OUT_FULL:  if (out_ready && !close) out_state <= OUT_EMPTY;
        default:                            out_state <= OUT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_wallace_mac_accumulator.sv
// Directed bench for the MAC accumulator: a default-width and a 16-bit
// accumulator instance share stimulus so saturation can be seen on the latter.
module tb_approx_wallace_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sum, in_carry;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, in_ready16;
  logic        out_valid, out_valid16;
  logic [23:0] out_acc;
  logic [15:0] out_acc16;
  logic [7:0]  out_count, out_count16;
  logic        out_sat, out_sat16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_wallace_mac_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_sat(out_sat)
  );

  approx_wallace_mac_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .out_count(out_count16), .out_sat(out_sat16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s, input logic [15:0] c, input logic l);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sum   = '0;
    in_carry = '0;
    in_last  = 1'b0;
  endtask

  logic [15:0] four_sum   [4] = '{16'd60, 16'd150, 16'd1, 16'd399};
  logic [15:0] four_carry [4] = '{16'd40, 16'd50, 16'd299, 16'd1};

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_acc",   out_acc,   0);
    check("rst_out_count", out_count, 0);
    rst = 1'b0;
    tick();

    // Single-beat group: 0x00F0 + 0x0010.
    drive(16'h00F0, 16'h0010, 1'b1);
    tick();
    idle();
    check("single_no_early_valid", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_acc",   out_acc,   64'h100);
    check("single_count", out_count, 1);
    check("single_sat",   out_sat,   0);
    tick();
    check("single_drained", out_valid, 0);

    // Four back-to-back beats resolving to 100, 200, 300, 400.
    for (int i = 0; i < 4; i++) begin
      drive(four_sum[i], four_carry[i], i == 3);
      check($sformatf("four_in_ready_%0d", i), in_ready, 1);
      tick();
    end
    idle();
    check("four_not_yet", out_valid, 0);
    tick();
    check("four_valid", out_valid, 1);
    check("four_acc",   out_acc,   1000);
    check("four_count", out_count, 4);
    tick();

    // Resolve add wraps modulo 2^16.
    drive(16'hFFFF, 16'h0002, 1'b1);
    tick();
    idle();
    tick();
    check("wrap_acc",   out_acc,   1);
    check("wrap_count", out_count, 1);
    tick();

    // Saturation on the 16-bit instance; the wide one holds the true sum.
    drive(16'hFFFF, 16'h0000, 1'b0);
    tick();
    drive(16'hFFFF, 16'h0000, 1'b1);
    tick();
    idle();
    tick();
    check("sat16_valid", out_valid16, 1);
    check("sat16_acc",   out_acc16,   64'hFFFF);
    check("sat16_sat",   out_sat16,   1);
    check("sat16_count", out_count16, 2);
    check("sat24_acc",   out_acc,     64'h1FFFE);
    check("sat24_sat",   out_sat,     0);
    tick();
    drive(16'd5, 16'd0, 1'b1);
    tick();
    idle();
    tick();
    check("post_sat_acc", out_acc16, 5);
    check("post_sat_sat", out_sat16, 0);
    tick();

    // Backpressure: held result 7, second closing beat 9 waits in stage 1.
    out_ready = 1'b0;
    drive(16'd7, 16'd0, 1'b1);
    tick();
    drive(16'd4, 16'd5, 1'b1);
    tick();
    idle();
    check("bp_in_ready_low", in_ready, 0);
    check("bp_held_acc",     out_acc,  7);
    tick();
    check("bp_still_valid", out_valid, 1);
    check("bp_still_acc",   out_acc,   7);
    check("bp_still_stall", in_ready,  0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_no_bubble", out_valid, 1);
    check("bp_second_acc", out_acc,  9);
    check("bp_second_cnt", out_count, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Mid-group reset while a result is also held.
    out_ready = 1'b0;
    drive(16'd3, 16'd0, 1'b1);
    tick();
    drive(16'd11, 16'd0, 1'b0);
    tick();
    drive(16'd22, 16'd0, 1'b0);
    tick();
    idle();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_acc",   out_acc,   0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_sat",   out_sat,   0);
    check("mid_rst_ready", in_ready,  1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    drive(16'd5, 16'd0, 1'b1);
    tick();
    idle();
    tick();
    check("fresh_valid", out_valid, 1);
    check("fresh_acc",   out_acc,   5);
    check("fresh_count", out_count, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
